// File: rtl/motor_pkg.sv
// Shared encodings for the motor command sequencer: drive commands, bridge pin
// patterns and FSM states.
package motor_pkg;

  typedef enum logic [1:0] {
    CMD_LEFT  = 2'b00,
    CMD_RIGHT = 2'b01,
    CMD_STOP  = 2'b10,
    CMD_FWD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DEAD = 2'b01,
    RUN  = 2'b10
  } state_e;

  // Patterns are ordered {as1, as2, bs1, bs2}
  localparam logic [3:0] PAT_LEFT  = 4'b1101;
  localparam logic [3:0] PAT_RIGHT = 4'b0111;
  localparam logic [3:0] PAT_FWD   = 4'b1111;
  localparam logic [3:0] PAT_STOP  = 4'b0000;

  function automatic logic [3:0] pattern_of(input cmd_e c);
    logic [3:0] p;
    case (c)
      CMD_LEFT:  p = PAT_LEFT;
      CMD_RIGHT: p = PAT_RIGHT;
      CMD_FWD:   p = PAT_FWD;
      default:   p = PAT_STOP;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM counter with duty compare; an all-ones duty means fully on.
module motor_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  logic [PWM_W-1:0] pwm_cnt_q;
  logic [PWM_W-1:0] pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty) || (&duty);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Drive-command sequencer for two H-bridge channels: dead time on direction
// changes, PWM-gated enables, timed hold, preemption and immediate stop.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 27000000,
  parameter int          CNT_W       = 26,
  parameter int unsigned DEAD_CYCLES = 1000,
  parameter int          PWM_W       = 8,
  parameter bit          PREEMPT     = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PWM_W-1:0] duty,
  output logic             e1,
  output logic             e2,
  output logic             as1,
  output logic             as2,
  output logic             bs1,
  output logic             bs2,
  output logic             busy,
  output logic             done
);

  if (HOLD_CYCLES < 1 ||
      longint'(HOLD_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(DEAD_CYCLES) >= (longint'(1) << CNT_W)) begin : g_cfg_err
    $error("motor_cmd_sequencer: CNT_W too narrow for HOLD_CYCLES/DEAD_CYCLES");
  end

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] dead_q, dead_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  cmd_e             cur_q, cur_d;
  logic [3:0]       pat_q, pat_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  cmd_e cmd_c;
  logic accept;
  logic is_stop;
  logic start_new;
  logic pwm_on;

  assign cmd_c   = cmd_e'(cmd);
  assign is_stop = (cmd_c == CMD_STOP);
  assign accept  = cmd_valid && cmd_ready;

  // Ready must reflect the command currently offered, so it is decoded from state.
  always_comb begin
    cmd_ready = 1'b1;
    case (state_q)
      DEAD:    cmd_ready = is_stop;
      RUN:     cmd_ready = PREEMPT || is_stop;
      default: cmd_ready = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    dead_d    = dead_q;
    duty_d    = duty_q;
    cur_d     = cur_q;
    pat_d     = pat_q;
    done_d    = 1'b0;
    start_new = 1'b0;

    case (state_q)
      IDLE: begin
        pat_d = PAT_STOP;
        if (accept && !is_stop) start_new = 1'b1;
      end
      DEAD: begin
        if (dead_q > CNT_W'(1)) begin
          dead_d = dead_q - CNT_W'(1);
        end else begin
          dead_d  = '0;
          hold_d  = HOLD_LD;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && !is_stop) begin
          // Same direction just extends the hold; a new direction needs dead time
          if (cmd_c == cur_q) begin
            hold_d = HOLD_LD;
            duty_d = duty;
          end else begin
            start_new = 1'b1;
          end
        end else if (hold_q > CNT_W'(1)) begin
          hold_d = hold_q - CNT_W'(1);
        end else begin
          hold_d  = '0;
          pat_d   = PAT_STOP;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pat_d   = PAT_STOP;
        hold_d  = '0;
        dead_d  = '0;
      end
    endcase

    if (start_new) begin
      cur_d  = cmd_c;
      duty_d = duty;
      pat_d  = pattern_of(cmd_c);
      if (DEAD_CYCLES == 0) begin
        state_d = RUN;
        hold_d  = HOLD_LD;
        dead_d  = '0;
      end else begin
        state_d = DEAD;
        dead_d  = DEAD_LD;
        hold_d  = '0;
      end
    end

    if (accept && is_stop) begin
      state_d = IDLE;
      pat_d   = PAT_STOP;
      hold_d  = '0;
      dead_d  = '0;
      done_d  = 1'b0;
    end

    e_d    = (state_d == RUN) && pwm_on;
    busy_d = (state_d != IDLE);
  end

  // The PWM compare sees the duty that will be in force after this edge
  motor_pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .clock  (clock),
    .reset_n(reset_n),
    .duty   (duty_d),
    .pwm_on (pwm_on)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      dead_q  <= '0;
      duty_q  <= '0;
      cur_q   <= CMD_STOP;
      pat_q   <= PAT_STOP;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      duty_q  <= duty_d;
      cur_q   <= cur_d;
      pat_q   <= pat_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign e1                 = e_q;
  assign e2                 = e_q;
  assign {as1, as2, bs1, bs2} = pat_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios plus random traffic, with
// a cycle-level reference model checking a PREEMPT=1 and a PREEMPT=0 instance.
module tb_motor_cmd_sequencer;

  localparam int HOLD  = 20;
  localparam int DEADC = 3;
  localparam int PW    = 4;
  localparam int DMAX  = (1 << PW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    cmd = 2'b10;
  logic          cmd_valid = 1'b0;
  logic [PW-1:0] duty = '0;

  logic [1:0] rdy_w, e1_w, e2_w, as1_w, as2_w, bs1_w, bs2_w, busy_w, done_w;

  always #5 clock = ~clock;

  motor_cmd_sequencer #(
    .HOLD_CYCLES(HOLD), .CNT_W(8), .DEAD_CYCLES(DEADC), .PWM_W(PW), .PREEMPT(1'b1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(rdy_w[0]), .duty(duty), .e1(e1_w[0]), .e2(e2_w[0]),
    .as1(as1_w[0]), .as2(as2_w[0]), .bs1(bs1_w[0]), .bs2(bs2_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  motor_cmd_sequencer #(
    .HOLD_CYCLES(HOLD), .CNT_W(8), .DEAD_CYCLES(DEADC), .PWM_W(PW), .PREEMPT(1'b0)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(rdy_w[1]), .duty(duty), .e1(e1_w[1]), .e2(e2_w[1]),
    .as1(as1_w[1]), .as2(as2_w[1]), .bs1(bs1_w[1]), .bs2(bs2_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Reference model: remaining dead/run cycles as plain integers
  int         m_dead [2];
  int         m_run  [2];
  logic [3:0] m_pat  [2];
  logic [1:0] m_cur  [2];
  int         m_duty [2];
  logic       m_done [2];
  logic       m_e    [2];
  int         pcnt;

  function automatic logic [3:0] pat_tab(input logic [1:0] c);
    case (c)
      2'b00:   return 4'b1101;
      2'b01:   return 4'b0111;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic exp_ready(input int i, input logic [1:0] c);
    if (m_dead[i] > 0) return (c == 2'b10);
    if (m_run[i] > 0)  return (i == 0) || (c == 2'b10);
    return 1'b1;
  endfunction

  task automatic model_start(input int i);
    m_cur[i]  = cmd;
    m_duty[i] = int'(duty);
    m_pat[i]  = pat_tab(cmd);
    m_dead[i] = DEADC;
    m_run[i]  = (DEADC == 0) ? HOLD : 0;
  endtask

  task automatic model_step();
    logic acc;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_dead[i] = 0; m_run[i] = 0; m_pat[i] = 4'b0000; m_cur[i] = 2'b10;
        m_duty[i] = 0; m_done[i] = 1'b0; m_e[i] = 1'b0;
      end
      pcnt = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        acc       = cmd_valid && exp_ready(i, cmd);
        m_done[i] = 1'b0;
        if (acc && cmd == 2'b10) begin
          m_dead[i] = 0; m_run[i] = 0; m_pat[i] = 4'b0000;
        end else if (m_dead[i] > 0) begin
          m_dead[i]--;
          if (m_dead[i] == 0) m_run[i] = HOLD;
        end else if (m_run[i] > 0) begin
          if (acc) begin
            if (cmd == m_cur[i]) begin
              m_run[i]  = HOLD;
              m_duty[i] = int'(duty);
            end else begin
              model_start(i);
            end
          end else begin
            m_run[i]--;
            if (m_run[i] == 0) begin
              m_done[i] = 1'b1;
              m_pat[i]  = 4'b0000;
            end
          end
        end else if (acc) begin
          model_start(i);
        end
        m_e[i] = (m_run[i] > 0) && (m_dead[i] == 0) && (pcnt < m_duty[i] || m_duty[i] == DMAX);
      end
      pcnt = (pcnt + 1) % (DMAX + 1);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Per-cycle comparison of every output of both instances against the model
  initial forever begin
    logic [8:0] got, exp;
    @(negedge clock);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        got = {e1_w[i], e2_w[i], as1_w[i], as2_w[i], bs1_w[i], bs2_w[i],
               busy_w[i], done_w[i], rdy_w[i]};
        exp = {m_e[i], m_e[i], m_pat[i], (m_dead[i] > 0 || m_run[i] > 0),
               m_done[i], exp_ready(i, cmd)};
        n_checks++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL model_cmp inst%0d t=%0t: got e1e2/pins/busy/done/rdy=%b required %b",
                   i, $time, got, exp);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  int         o_ehi, o_busy, o_done, o_pat, o_elow_busy;
  logic [3:0] obs_pat;
  logic       o_rdy_a, o_rdy_b;

  task automatic clear_obs();
    o_ehi = 0; o_busy = 0; o_done = 0; o_pat = 0; o_elow_busy = 0;
  endtask

  task automatic observe(input int n);
    repeat (n) begin
      @(negedge clock);
      o_ehi       += int'(e1_w[0]);
      o_busy      += int'(busy_w[0]);
      o_done      += int'(done_w[0]);
      o_pat       += int'({as1_w[0], as2_w[0], bs1_w[0], bs2_w[0]} == obs_pat);
      o_elow_busy += int'(busy_w[0] && !e1_w[0]);
      o_rdy_a      = rdy_w[0];
      o_rdy_b      = rdy_w[1];
      @(posedge clock);
      #2;
    end
  endtask

  task automatic send(input logic [1:0] c, input int d);
    cmd       = c;
    duty      = PW'(d);
    cmd_valid = 1'b1;
    observe(1);
    cmd_valid = 1'b0;
    $display("txn cmd=%0d duty=%0d ready_a=%0b ready_b=%0b t=%0t", c, d, o_rdy_a, o_rdy_b, $time);
  endtask

  initial begin
    int ehi0;
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    check("reset_outputs", int'({e1_w[0], e2_w[0], as1_w[0], as2_w[0], bs1_w[0], bs2_w[0], busy_w[0], done_w[0]}), 0);
    check("reset_ready", int'(rdy_w[0]), 1);
    chk_en = 1'b1;

    // Forward at full duty
    clear_obs(); obs_pat = 4'b1111;
    send(2'b11, 15);
    observe(28);
    check("fwd_dead_cycles", o_elow_busy, 3);
    check("fwd_run_cycles", o_ehi, 20);
    check("fwd_pattern_cycles", o_pat, 23);
    check("fwd_done", o_done, 1);

    // Left at duty 4: 4 of any 16 consecutive RUN cycles
    clear_obs(); obs_pat = 4'b1101;
    send(2'b00, 4);
    observe(3);
    check("left_dead_pattern", o_pat, 3);
    ehi0 = o_ehi;
    observe(16);
    check("left_pwm_4of16", o_ehi - ehi0, 4);
    observe(10);
    check("left_done", o_done, 1);

    // Duty 0 never energises but still times out
    clear_obs();
    send(2'b00, 0);
    observe(28);
    check("duty0_ehi", o_ehi, 0);
    check("duty0_done", o_done, 1);

    // Direction change mid-RUN
    clear_obs(); obs_pat = 4'b0111;
    send(2'b11, 15);
    observe(12);
    send(2'b01, 15);
    observe(30);
    check("chg_ehi", o_ehi, 30);
    check("chg_dead_total", o_elow_busy, 6);
    check("chg_right_pattern", o_pat, 23);
    check("chg_done", o_done, 1);

    // Same-command preemption extends RUN without a gap
    clear_obs();
    send(2'b11, 15);
    observe(12);
    send(2'b11, 15);
    observe(25);
    check("pre_ehi", o_ehi, 30);
    check("pre_gap", o_elow_busy, 3);
    check("pre_done", o_done, 1);

    // Stop in DEAD, in RUN and in IDLE
    clear_obs(); obs_pat = 4'b0000;
    send(2'b11, 15);
    observe(1);
    send(2'b10, 0);
    check("stop_dead_ack", int'(o_rdy_a), 1);
    clear_obs();
    observe(5);
    check("stop_dead_busy", o_busy, 0);
    check("stop_dead_pins", o_pat, 5);
    send(2'b11, 15);
    observe(8);
    send(2'b10, 0);
    clear_obs();
    observe(30);
    check("stop_run_busy", o_busy, 0);
    check("stop_run_done", o_done, 0);
    send(2'b10, 0);
    check("stop_idle_ack", int'(o_rdy_a), 1);
    observe(3);
    check("stop_idle_busy", o_busy, 0);

    // Reset mid-RUN
    send(2'b11, 15);
    observe(10);
    reset_n = 1'b0;
    observe(1);
    check("rst_mid_outputs", int'({e1_w[0], as1_w[0], as2_w[0], bs1_w[0], bs2_w[0], busy_w[0], done_w[0]}), 0);
    check("rst_mid_ready", int'(rdy_w[0]), 1);
    reset_n = 1'b1;
    observe(2);

    // PREEMPT=0 refuses a direction change in RUN
    send(2'b11, 15);
    observe(8);
    send(2'b01, 15);
    check("nopre_ready", int'(o_rdy_b), 0);
    observe(2);
    check("nopre_pins", int'({as1_w[1], as2_w[1], bs1_w[1], bs2_w[1]}), 15);
    check("nopre_busy", int'(busy_w[1]), 1);
    observe(40);

    // Random traffic against the model
    repeat (3000) begin
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd       = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       duty = '0;
        1:       duty = PW'(DMAX);
        default: duty = PW'($urandom_range(0, DMAX));
      endcase
      reset_n = ($urandom_range(0, 499) != 0);
      @(posedge clock);
      #2;
    end
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    repeat (5) @(posedge clock);
    #2;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
